fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter that lets NUM_REQ producers share a single FIFO write
// port. A winner holds the port for one tenure of up to MAX_BURST words. The
// tenure ends when the owner drops its request or writes its last word. Each
// release is followed by one IDLE cycle, and the next search starts one index
// past the previous owner.
//
// Handshake: req[i] is producer i's "valid". accept[i] is the "ready" half of
// the handshake. A word moves only in a cycle where req[i] and accept[i] are
// both high, and accept[i] is only ever high when req[i] is high. The
// producer must hold its word on req_data while req[i] is high and accept[i]
// is low. It advances to its next word after a cycle in which accept[i] was
// high.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   req       per-producer request (valid)
//   req_data  packed words, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      FIFO full flag; stalls any write
//   grant     one-hot current owner, zero in IDLE
//   accept    one-hot, the owner's word is written this cycle
//   wr_en     FIFO write enable
//   data_in   FIFO write data, zero when wr_en is low
//   busy      high while in GRANT (exposes the FSM state)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            accept,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]   pick;
  logic               pick_valid;
  logic [IDX_W-1:0]   next_owner;
  logic [NUM_REQ-1:0] owner_oh;
  logic               accept_hit;
  logic               last_beat;

  // Rotating priority search: rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ.
  always_comb begin : rr_search
    int idx;
    idx        = 0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick       = IDX_W'(idx);
      end
    end
  end

  assign next_owner = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
  assign owner_oh   = NUM_REQ'(1) << owner_q;

  // A write happens only while the owner presents a word and the FIFO has
  // room. Reset masks it combinationally so the reset cycle never writes.
  assign accept_hit = (state_q == GRANT) && req[owner_q] && !full && !rst;
  assign last_beat  = accept_hit && (burst_cnt_q == 4'(MAX_BURST - 1));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid && !full) begin
          state_d     = GRANT;
          owner_d     = pick;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        // A dropped request wins over a write. A full stall with req held
        // leaves the owner, counter and pointer unchanged.
        if (!req[owner_q] || last_beat) begin
          state_d  = IDLE;
          rr_ptr_d = next_owner;
        end else if (accept_hit) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign busy    = (state_q == GRANT) && !rst;
  assign grant   = busy ? owner_oh : '0;
  assign accept  = accept_hit ? owner_oh : '0;
  assign wr_en   = accept_hit;
  assign data_in = accept_hit ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule
